// File: rtl/alu_dispatch_pkg.sv
// rtl/alu_dispatch_pkg.sv - ALU function codes, dispatcher state encodings and operand sanitising helpers
package alu_dispatch_pkg;

    localparam logic [2:0] ALU_ADDSUB = 3'd0;
    localparam logic [2:0] ALU_SLL    = 3'd1;
    localparam logic [2:0] ALU_SLT    = 3'd2;
    localparam logic [2:0] ALU_SLTU   = 3'd3;
    localparam logic [2:0] ALU_XOR    = 3'd4;
    localparam logic [2:0] ALU_SRLA   = 3'd5;
    localparam logic [2:0] ALU_OR     = 3'd6;
    localparam logic [2:0] ALU_AND    = 3'd7;

    localparam logic [2:0] DSP_IDLE  = 3'd0;
    localparam logic [2:0] DSP_ISSUE = 3'd1;
    localparam logic [2:0] DSP_WAIT  = 3'd2;
    localparam logic [2:0] DSP_DRAIN = 3'd3;
    localparam logic [2:0] DSP_WB    = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = DSP_IDLE,
        ST_ISSUE = DSP_ISSUE,
        ST_WAIT  = DSP_WAIT,
        ST_DRAIN = DSP_DRAIN,
        ST_WB    = DSP_WB
    } dsp_state_e;

    // Immediate forms have no SUBI; only SRAI keeps its arithmetic-select bit.
    function automatic logic [6:0] sanitise_fun7(input logic [2:0] fun3,
                                                 input logic [6:0] fun7,
                                                 input logic       is_imm);
        if (!is_imm)
            return fun7;
        if (fun3 == ALU_SRLA)
            return {1'b0, fun7[5], 5'b0};
        return 7'd0;
    endfunction

    function automatic logic [31:0] sanitise_rs2(input logic [2:0]  fun3,
                                                 input logic [31:0] b);
        if ((fun3 == ALU_SLL) || (fun3 == ALU_SRLA))
            return {27'b0, b[4:0]};
        return b;
    endfunction

endpackage

// File: rtl/alu_dispatch_wdt.sv
// rtl/alu_dispatch_wdt.sv - saturating timeout counter for the ALU done wait
module alu_dispatch_wdt #(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Fires on the cycle that would bring the count to TIMEOUT_CYC.
    assign expired = en && (cnt >= CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/alu_dispatch.sv
// rtl/alu_dispatch.sv - execute-stage initiator for the ALU start/done handshake with writeback port
module alu_dispatch
    import alu_dispatch_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fun3,
    input  logic [6:0]  in_fun7,
    input  logic        in_is_imm,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [4:0]  in_rd,
    output logic        alu_start,
    output logic [2:0]  alu_fun3,
    output logic [6:0]  alu_fun7,
    output logic [31:0] alu_rs1,
    output logic [31:0] alu_rs2,
    input  logic [31:0] alu_res,
    input  logic        alu_zero,
    input  logic        alu_neg,
    input  logic        alu_done,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_zero,
    output logic        wb_neg,
    output logic        wb_err
);

    dsp_state_e  state;
    logic        rdy_en;
    logic [4:0]  rd_q;
    logic        wdt_clr;
    logic        wdt_en;
    logic        wdt_expired;
    logic        accept;

    alu_dispatch_wdt #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) u_wdt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (wdt_clr),
        .en      (wdt_en),
        .expired (wdt_expired)
    );

    assign wdt_en  = (state == ST_WAIT);
    assign wdt_clr = (state != ST_WAIT) || alu_done || wdt_expired;

    // rdy_en keeps in_ready low until the first clock after reset release.
    assign in_ready = ((state == ST_IDLE) && rdy_en) || ((state == ST_WB) && wb_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rdy_en    <= 1'b0;
            rd_q      <= '0;
            alu_start <= 1'b0;
            alu_fun3  <= '0;
            alu_fun7  <= '0;
            alu_rs1   <= '0;
            alu_rs2   <= '0;
            wb_valid  <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
            wb_zero   <= 1'b0;
            wb_neg    <= 1'b0;
            wb_err    <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (accept) begin
                alu_fun3 <= in_fun3;
                alu_fun7 <= sanitise_fun7(in_fun3, in_fun7, in_is_imm);
                alu_rs1  <= in_a;
                alu_rs2  <= sanitise_rs2(in_fun3, in_b);
                rd_q     <= in_rd;
            end
            case (state)
                ST_IDLE: begin
                    if (accept)
                        state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    alu_start <= 1'b1;
                    state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (alu_done) begin
                        alu_start <= 1'b0;
                        wb_data   <= alu_res;
                        wb_zero   <= alu_zero;
                        wb_neg    <= alu_neg;
                        wb_err    <= 1'b0;
                        state     <= ST_DRAIN;
                    end else if (wdt_expired) begin
                        alu_start <= 1'b0;
                        wb_data   <= '0;
                        wb_zero   <= 1'b0;
                        wb_neg    <= 1'b0;
                        wb_err    <= 1'b1;
                        state     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Waiting for done to fall guarantees the next start is a fresh edge.
                    if (!alu_done) begin
                        wb_valid <= 1'b1;
                        wb_rd    <= rd_q;
                        state    <= ST_WB;
                    end
                end
                ST_WB: begin
                    if (wb_ready) begin
                        wb_valid <= 1'b0;
                        state    <= in_valid ? ST_ISSUE : ST_IDLE;
                    end
                end
                default: begin
                    alu_start <= 1'b0;
                    wb_valid  <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_dispatch.sv
// tb/tb_alu_dispatch.sv - directed self-checking bench for alu_dispatch with a behavioural ALU
module tb_alu_dispatch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_fun3 = '0;
    logic [6:0]  in_fun7 = '0;
    logic        in_is_imm = 1'b0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [4:0]  in_rd = '0;
    logic        alu_start;
    logic [2:0]  alu_fun3;
    logic [6:0]  alu_fun7;
    logic [31:0] alu_rs1;
    logic [31:0] alu_rs2;
    logic [31:0] alu_res;
    logic        alu_zero;
    logic        alu_neg;
    logic        alu_done;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_zero;
    logic        wb_neg;
    logic        wb_err;

    int n_assert = 0;
    int n_fail   = 0;

    logic       hang_mode = 1'b0;
    logic [3:0] alu_delay = 4'd2;
    logic [3:0] alu_cnt;

    int start_edges = 0;
    int start_hi    = 0;
    int wb_seen     = 0;
    int viol        = 0;
    logic prev_start = 1'b0;
    logic prev_done  = 1'b0;

    alu_dispatch #(.TIMEOUT_CYC(16), .CNT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fun3   (in_fun3),
        .in_fun7   (in_fun7),
        .in_is_imm (in_is_imm),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_rd     (in_rd),
        .alu_start (alu_start),
        .alu_fun3  (alu_fun3),
        .alu_fun7  (alu_fun7),
        .alu_rs1   (alu_rs1),
        .alu_rs2   (alu_rs2),
        .alu_res   (alu_res),
        .alu_zero  (alu_zero),
        .alu_neg   (alu_neg),
        .alu_done  (alu_done),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .wb_zero   (wb_zero),
        .wb_neg    (wb_neg),
        .wb_err    (wb_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_calc(input logic [2:0] f3, input logic [6:0] f7,
                                             input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0: return f7[5] ? (a - b) : (a + b);
            3'd1: return a << b[4:0];
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return f7[5] ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    // ALU: done after alu_delay cycles of start, held until start falls.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_done <= 1'b0;
            alu_cnt  <= '0;
            alu_res  <= '0;
            alu_zero <= 1'b0;
            alu_neg  <= 1'b0;
        end else if (!alu_start) begin
            alu_done <= 1'b0;
            alu_cnt  <= '0;
        end else if (!alu_done && !hang_mode) begin
            if (alu_cnt + 4'd1 >= alu_delay) begin
                alu_done <= 1'b1;
                alu_res  <= alu_calc(alu_fun3, alu_fun7, alu_rs1, alu_rs2);
                alu_zero <= (alu_calc(alu_fun3, alu_fun7, alu_rs1, alu_rs2) == 32'd0);
                alu_neg  <= alu_calc(alu_fun3, alu_fun7, alu_rs1, alu_rs2) >> 31 != 32'd0;
            end else begin
                alu_cnt <= alu_cnt + 4'd1;
            end
        end
    end

    always @(negedge clk) begin
        if (alu_start && !prev_start) start_edges <= start_edges + 1;
        if (alu_start) start_hi <= start_hi + 1;
        if (wb_valid) wb_seen <= wb_seen + 1;
        if (rst_n && !hang_mode && prev_start && !alu_start && !prev_done) viol <= viol + 1;
        if (rst_n && prev_start && prev_done && alu_start) viol <= viol + 1;
        prev_start <= alu_start;
        prev_done  <= alu_done;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [2:0] f3, input logic [6:0] f7, input logic imm,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        int n;
        @(negedge clk);
        in_valid = 1'b1; in_fun3 = f3; in_fun7 = f7; in_is_imm = imm;
        in_a = a; in_b = b; in_rd = rd;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_accept", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_wb();
        int n;
        n = 0;
        @(negedge clk);
        while (!wb_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("wb_valid_seen", 32'(wb_valid), 32'd1);
    endtask

    task automatic pop();
        @(negedge clk);
        wb_ready = 1'b1;
        @(posedge clk);
        #1 wb_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end

    initial begin
        int e0, h0, w0, unstable, rdy_bad;
        logic [31:0] d;

        // Reset state
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_alu_start", 32'(alu_start), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_err", 32'(wb_err), 32'd0);
        chk("rst_alu_rs1", alu_rs1, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rel_in_ready_pre_clk", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 chk("rel_in_ready_post_clk", 32'(in_ready), 32'd1);

        // 1: ADD 5+7
        e0 = start_edges;
        send(3'd0, 7'h00, 1'b0, 32'd5, 32'd7, 5'd3);
        wait_wb();
        chk("add_data", wb_data, 32'd12);
        chk("add_zero", 32'(wb_zero), 32'd0);
        chk("add_neg", 32'(wb_neg), 32'd0);
        chk("add_err", 32'(wb_err), 32'd0);
        chk("add_rd", 32'(wb_rd), 32'd3);
        chk("add_start_low_in_wb", 32'(alu_start), 32'd0);
        chk("add_start_edges", 32'(start_edges - e0), 32'd1);
        chk("add_start_protocol", 32'(viol), 32'd0);
        pop();

        // 2: SUB
        send(3'd0, 7'h20, 1'b0, 32'd3, 32'd3, 5'd4);
        wait_wb();
        chk("sub_eq_data", wb_data, 32'd0);
        chk("sub_eq_zero", 32'(wb_zero), 32'd1);
        pop();
        send(3'd0, 7'h20, 1'b0, 32'd1, 32'd2, 5'd5);
        wait_wb();
        chk("sub_neg_data", wb_data, 32'hFFFF_FFFF);
        chk("sub_neg_neg", 32'(wb_neg), 32'd1);
        chk("sub_neg_zero", 32'(wb_zero), 32'd0);
        pop();

        // 3: operand sanitising
        send(3'd1, 7'h00, 1'b0, 32'd1, 32'h0000_0024, 5'd6);
        chk("sll_rs2", alu_rs2, 32'd4);
        wait_wb();
        chk("sll_data", wb_data, 32'h10);
        pop();
        send(3'd0, 7'h20, 1'b1, 32'd10, 32'd3, 5'd7);
        chk("addi_fun7", 32'(alu_fun7), 32'd0);
        wait_wb();
        chk("addi_data", wb_data, 32'd13);
        pop();
        send(3'd5, 7'h20, 1'b1, 32'h8000_0000, 32'h0000_0404, 5'd8);
        chk("srai_fun7", 32'(alu_fun7), 32'h20);
        chk("srai_rs2", alu_rs2, 32'd4);
        wait_wb();
        chk("srai_data", wb_data, 32'hF800_0000);
        chk("srai_neg", 32'(wb_neg), 32'd1);
        pop();

        // 4: writeback backpressure then back-to-back accept
        send(3'd6, 7'h00, 1'b0, 32'hF0, 32'h0F, 5'd9);
        wait_wb();
        d = wb_data;
        chk("or_data", wb_data, 32'hFF);
        unstable = 0;
        rdy_bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (wb_data !== d || wb_valid !== 1'b1 || wb_rd !== 5'd9) unstable++;
            if (in_ready !== 1'b0) rdy_bad++;
        end
        chk("bp_wb_stable", 32'(unstable), 32'd0);
        chk("bp_in_ready_low", 32'(rdy_bad), 32'd0);
        in_valid = 1'b1; in_fun3 = 3'd4; in_fun7 = 7'h00; in_is_imm = 1'b0;
        in_a = 32'hFF; in_b = 32'h0F; in_rd = 5'd10;
        wb_ready = 1'b1;
        #1 chk("b2b_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wb_ready = 1'b0;
        chk("b2b_latched_rs1", alu_rs1, 32'hFF);
        chk("b2b_wb_valid_drop", 32'(wb_valid), 32'd0);
        chk("b2b_start_not_yet", 32'(alu_start), 32'd0);
        @(posedge clk);
        #1 chk("b2b_start_rise", 32'(alu_start), 32'd1);
        wait_wb();
        chk("xor_data", wb_data, 32'hF0);
        chk("xor_rd", 32'(wb_rd), 32'd10);
        pop();

        // 5: timeout
        hang_mode = 1'b1;
        h0 = start_hi;
        send(3'd7, 7'h00, 1'b0, 32'hFF, 32'h0F, 5'd11);
        wait_wb();
        chk("to_err", 32'(wb_err), 32'd1);
        chk("to_data", wb_data, 32'd0);
        chk("to_start_cycles", 32'(start_hi - h0), 32'd16);
        pop();
        hang_mode = 1'b0;
        send(3'd0, 7'h00, 1'b0, 32'd100, 32'd23, 5'd12);
        wait_wb();
        chk("post_to_data", wb_data, 32'd123);
        chk("post_to_err", 32'(wb_err), 32'd0);
        pop();

        // 6: reset mid-op
        hang_mode = 1'b1;
        send(3'd0, 7'h00, 1'b0, 32'd1, 32'd1, 5'd13);
        repeat (4) @(negedge clk);
        chk("pre_rst_start", 32'(alu_start), 32'd1);
        w0 = wb_seen;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_start", 32'(alu_start), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        hang_mode = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_no_wb", 32'(wb_seen - w0), 32'd0);
        send(3'd2, 7'h00, 1'b0, 32'h8000_0000, 32'd0, 5'd14);
        wait_wb();
        chk("slt_data", wb_data, 32'd1);
        chk("slt_err", 32'(wb_err), 32'd0);
        pop();

        chk("final_start_protocol", 32'(viol), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
